// File: rtl/ex_branch_resolve.sv
// EX-stage branch resolution: evaluates the branch condition, compares it with the
// ID-stage prediction, and issues a one-cycle redirect/flush on a mispredict.
module ex_branch_resolve (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallE,
    input  logic [4:0]  branch_judge_controlE,
    input  logic [31:0] pc_plus4E,
    input  logic [31:0] pcbranchE,
    input  logic        jump_conflictE,
    input  logic [31:0] rs_valueE,
    input  logic [31:0] rt_valueE,
    input  logic [31:0] pc_plus4D,
    output logic        predict_takenD,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flushD_req,
    output logic        flushE_req,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        C_BEQ    = 3'd0,
        C_BNE    = 3'd1,
        C_BGEZ   = 3'd2,
        C_BGTZ   = 3'd3,
        C_BLEZ   = 3'd4,
        C_BLTZ   = 3'd5,
        C_BGEZAL = 3'd6,
        C_BLTZAL = 3'd7
    } cond_t;

    state_t      state;
    logic [1:0]  bht [16];
    logic        taken;
    logic        resolve;
    logic        mispredict;
    logic        rs_zero;
    logic        rs_neg;
    logic [31:0] correct_pc;
    logic [3:0]  upd_idx;
    cond_t       cond;

    // Address bits outside the BHT index and the reserved control bit carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{pc_plus4D[31:6], pc_plus4D[1:0], pc_plus4E[1:0], branch_judge_controlE[3]};

    assign cond    = cond_t'(branch_judge_controlE[2:0]);
    assign rs_zero = (rs_valueE == 32'd0);
    assign rs_neg  = rs_valueE[31];
    assign upd_idx = pc_plus4E[5:2];

    always_comb begin
        taken = 1'b0;
        case (cond)
            C_BEQ:             taken = (rs_valueE == rt_valueE);
            C_BNE:             taken = (rs_valueE != rt_valueE);
            C_BGEZ, C_BGEZAL:  taken = !rs_neg;
            C_BGTZ:            taken = !rs_neg && !rs_zero;
            C_BLEZ:            taken = rs_neg || rs_zero;
            C_BLTZ, C_BLTZAL:  taken = rs_neg;
            default:           taken = 1'b0;
        endcase
    end

    // Instructions seen while redirecting are on the wrong path and never resolve.
    assign resolve    = !stallE && branch_judge_controlE[4] && (state == IDLE);
    assign mispredict = resolve && (taken != jump_conflictE);
    assign correct_pc = taken ? pcbranchE : (pc_plus4E + 32'd4);

    // Lookup reads the registered table, so a same-index update this cycle is seen next cycle.
    assign predict_takenD = bht[pc_plus4D[5:2]][1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            flushD_req     <= 1'b0;
            flushE_req     <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        flushD_req     <= 1'b1;
                        flushE_req     <= 1'b1;
                        redirect_pc    <= correct_pc;
                    end
                end
                REDIRECT: begin
                    state          <= IDLE;
                    redirect_valid <= 1'b0;
                    flushD_req     <= 1'b0;
                    flushE_req     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt     <= 32'd0;
            mispredict_cnt <= 32'd0;
        end else if (resolve) begin
            if (branch_cnt != 32'hFFFF_FFFF)
                branch_cnt <= branch_cnt + 32'd1;
            if (mispredict && (mispredict_cnt != 32'hFFFF_FFFF))
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    // NOTE: the BHT is a small flop array, not RAM, so it is reset to weakly-not-taken;
    // a macro RAM could not be cleared in one cycle like this.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++)
                bht[i] <= 2'b01;
        end else if (resolve) begin
            if (taken && (bht[upd_idx] != 2'b11))
                bht[upd_idx] <= bht[upd_idx] + 2'b01;
            else if (!taken && (bht[upd_idx] != 2'b00))
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
        end
    end

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed bench for ex_branch_resolve: redirect timing, condition decode, BHT
// update/lookup ordering, stall handling and reset during redirect.
module tb_ex_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallE;
    logic [4:0]  branch_judge_controlE;
    logic [31:0] pc_plus4E;
    logic [31:0] pcbranchE;
    logic        jump_conflictE;
    logic [31:0] rs_valueE;
    logic [31:0] rt_valueE;
    logic [31:0] pc_plus4D;
    logic        predict_takenD;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flushD_req;
    logic        flushE_req;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int errors = 0;
    int checks = 0;

    ex_branch_resolve dut (
        .clk                   (clk),
        .rst                   (rst),
        .stallE                (stallE),
        .branch_judge_controlE (branch_judge_controlE),
        .pc_plus4E             (pc_plus4E),
        .pcbranchE             (pcbranchE),
        .jump_conflictE        (jump_conflictE),
        .rs_valueE             (rs_valueE),
        .rt_valueE             (rt_valueE),
        .pc_plus4D             (pc_plus4D),
        .predict_takenD        (predict_takenD),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .flushD_req            (flushD_req),
        .flushE_req            (flushE_req),
        .branch_cnt            (branch_cnt),
        .mispredict_cnt        (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic [2:0] cond, input logic [31:0] rs, input logic [31:0] rt,
                              input logic jc, input logic [31:0] pc4, input logic [31:0] tgt);
        branch_judge_controlE = {2'b10, cond};
        rs_valueE             = rs;
        rt_valueE             = rt;
        jump_conflictE        = jc;
        pc_plus4E             = pc4;
        pcbranchE             = tgt;
    endtask

    task automatic no_branch();
        branch_judge_controlE = 5'd0;
        stallE                = 1'b0;
    endtask

    task automatic check_redirect(input string tag, input logic v, input logic [31:0] pc);
        check({tag, "_valid"},  {31'd0, redirect_valid}, {31'd0, v});
        check({tag, "_flushD"}, {31'd0, flushD_req},     {31'd0, v});
        check({tag, "_flushE"}, {31'd0, flushE_req},     {31'd0, v});
        check({tag, "_pc"},     redirect_pc,             pc);
    endtask

    typedef struct {
        logic [2:0]  cond;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        jc;
    } vec_t;

    // Correctly predicted branches: none may redirect.
    vec_t vecs [9] = '{
        '{3'd4, 32'h0000_0000, 32'd0, 1'b1},
        '{3'd4, 32'hFFFF_FFFF, 32'd0, 1'b1},
        '{3'd4, 32'h0000_0005, 32'd0, 1'b0},
        '{3'd3, 32'h8000_0000, 32'd0, 1'b0},
        '{3'd3, 32'h0000_0001, 32'd0, 1'b1},
        '{3'd6, 32'h0000_0000, 32'd0, 1'b1},
        '{3'd7, 32'h0000_0001, 32'd0, 1'b0},
        '{3'd1, 32'h0000_0001, 32'd2, 1'b1},
        '{3'd0, 32'h0000_0003, 32'd4, 1'b0}
    };

    initial begin
        rst = 1'b0;
        no_branch();
        pc_plus4E = 32'd0; pcbranchE = 32'd0; jump_conflictE = 1'b0;
        rs_valueE = 32'd0; rt_valueE = 32'd0; pc_plus4D = 32'd0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        check_redirect("rst", 1'b0, 32'd0);
        check("rst_bcnt", branch_cnt, 32'd0);
        check("rst_mcnt", mispredict_cnt, 32'd0);
        pc_plus4D = 32'h0000_0000; #1 check("rst_pred0", {31'd0, predict_takenD}, 32'd0);
        pc_plus4D = 32'h0000_0044; #1 check("rst_pred1", {31'd0, predict_takenD}, 32'd0);
        pc_plus4D = 32'hFFFF_FFFC; #1 check("rst_pred15", {31'd0, predict_takenD}, 32'd0);

        // BEQ taken, predicted not taken: one-cycle redirect to target
        set_branch(3'd0, 32'd5, 32'd5, 1'b0, 32'h0000_0010, 32'h0000_0100);
        tick();
        check_redirect("beq_redir", 1'b1, 32'h0000_0100);
        check("beq_mcnt", mispredict_cnt, 32'd1);
        check("beq_bcnt", branch_cnt, 32'd1);
        tick(); // wrong-path branch still presented: must be ignored
        check_redirect("beq_after", 1'b0, 32'h0000_0100);
        check("beq_ignored_bcnt", branch_cnt, 32'd1);
        check("beq_ignored_mcnt", mispredict_cnt, 32'd1);
        pc_plus4D = 32'h0000_0010; #1 check("beq_bht4", {31'd0, predict_takenD}, 32'd1);

        // BNE not taken, predicted not taken at 0x40: BHT[0] 01->00
        set_branch(3'd1, 32'd7, 32'd7, 1'b0, 32'h0000_0040, 32'h0000_0300);
        tick();
        check("bne_valid", {31'd0, redirect_valid}, 32'd0);
        check("bne_bcnt", branch_cnt, 32'd2);

        // BLTZ taken, predicted taken at 0x44: lookup same index sees old value
        set_branch(3'd5, 32'h8000_0000, 32'd0, 1'b1, 32'h0000_0044, 32'h0000_0400);
        pc_plus4D = 32'h0000_0044;
        #1 check("bltz_pred_pre", {31'd0, predict_takenD}, 32'd0);
        tick();
        check("bltz_pred_post", {31'd0, predict_takenD}, 32'd1);
        check("bltz_valid", {31'd0, redirect_valid}, 32'd0);
        check("bltz_bcnt", branch_cnt, 32'd3);

        // BEQ taken at 0x40 predicted taken: BHT[0] 00->01, still predicts not taken
        set_branch(3'd0, 32'd9, 32'd9, 1'b1, 32'h0000_0040, 32'h0000_0500);
        tick();
        pc_plus4D = 32'h0000_0040; #1 check("bht0_pred", {31'd0, predict_takenD}, 32'd0);
        check("bht0_valid", {31'd0, redirect_valid}, 32'd0);

        // Non-branch with mispredict-looking operands: nothing happens
        branch_judge_controlE = 5'b00000;
        jump_conflictE = 1'b1;
        tick();
        check("nobr_valid", {31'd0, redirect_valid}, 32'd0);
        check("nobr_bcnt", branch_cnt, 32'd4);

        // Mispredicting BGEZ held by stall for 3 cycles
        set_branch(3'd2, 32'd1, 32'd0, 1'b0, 32'h0000_0088, 32'h0000_0200);
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'd0, redirect_valid}, 32'd0);
            check("stall_bcnt", branch_cnt, 32'd4);
        end
        stallE = 1'b0;
        tick();
        check_redirect("stall_redir", 1'b1, 32'h0000_0200);
        check("stall_bcnt_once", branch_cnt, 32'd5);
        check("stall_mcnt", mispredict_cnt, 32'd2);
        stallE = 1'b1; // stall during REDIRECT must not extend it
        tick();
        check_redirect("stall_end", 1'b0, 32'h0000_0200);
        no_branch();

        // Condition decode table, all correctly predicted
        foreach (vecs[i]) begin
            set_branch(vecs[i].cond, vecs[i].rs, vecs[i].rt, vecs[i].jc, 32'h0000_0060, 32'h0000_0600);
            tick();
            check($sformatf("cond%0d_valid", i), {31'd0, redirect_valid}, 32'd0);
        end
        no_branch();
        check("table_bcnt", branch_cnt, 32'd14);
        check("table_mcnt", mispredict_cnt, 32'd2);

        // BGTZ rs=0 predicted taken at 0xFFFFFFFC: fall-through wraps to 0
        set_branch(3'd3, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0700);
        tick();
        check_redirect("wrap_redir", 1'b1, 32'h0000_0000);
        check("wrap_mcnt", mispredict_cnt, 32'd3);
        no_branch();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_redirect("rst_abort", 1'b0, 32'd0);
        check("rst_abort_bcnt", branch_cnt, 32'd0);
        check("rst_abort_mcnt", mispredict_cnt, 32'd0);
        pc_plus4D = 32'h0000_0044; #1 check("rst_abort_pred", {31'd0, predict_takenD}, 32'd0);
        tick();
        check("rst_abort_idle", {31'd0, redirect_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_branch_resolve.md
EX_BRANCH_RESOLVE -- requirements
Module: ex_branch_resolve

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge).
REQ-002 SHALL have ports: stallE  in  1  EX stage held; branch_judge_controlE  in  5  [4]=branch, [2:0]=cond (0 BEQ, 1 BNE, 2 BGEZ, 3 BGTZ, 4 BLEZ, 5 BLTZ, 6 BGEZAL, 7 BLTZAL), [3] reserved.
REQ-003 SHALL have ports: pc_plus4E  in  32  delay-slot address; pcbranchE  in  32  branch target; jump_conflictE  in  1  ID predicted taken and fetched from target.
REQ-004 SHALL have ports: rs_valueE, rt_valueE  in  32 each  forwarded operands.
REQ-005 SHALL have ports: pc_plus4D  in  32  ID-stage lookup PC; predict_takenD  out  1  BHT prediction for ID.
REQ-006 SHALL have ports: redirect_valid  out  1; redirect_pc  out  32; flushD_req, flushE_req  out  1 each.
REQ-007 SHALL have ports: branch_cnt, mispredict_cnt  out  32 each  statistics.

Function
REQ-008 Resolve event SHALL occur in a cycle when rst=1, stallE=0, branch_judge_controlE[4]=1 and state=IDLE.
REQ-009 Actual taken SHALL be computed combinationally: BEQ rs==rt; BNE rs!=rt; BGEZ/BGEZAL rs[31]==0; BGTZ rs[31]==0 and rs!=0; BLEZ rs[31]==1 or rs==0; BLTZ/BLTZAL rs[31]==1 (signed 32-bit).
REQ-010 Mispredict SHALL be actual taken != jump_conflictE on a resolve event.
REQ-011 Correct PC SHALL be pcbranchE if taken, else pc_plus4E+4 (32-bit modular add, wrap from 0xFFFFFFFC to 0x00000000).
REQ-012 FSM SHALL have two states: IDLE, REDIRECT; IDLE->REDIRECT on the clk edge of a mispredicting resolve event; REDIRECT->IDLE unconditionally on the next edge.
REQ-013 In REDIRECT, redirect_valid, flushD_req and flushE_req SHALL be 1 and redirect_pc SHALL hold the registered correct PC; in IDLE all three SHALL be 0 and redirect_pc SHALL hold its last value.
REQ-014 Redirect latency SHALL be exactly one cycle: outputs are asserted the cycle after the resolve event.
REQ-015 In REDIRECT, EX inputs SHALL be ignored (wrong path): no resolve, no BHT update, no counter update.
REQ-016 BHT SHALL be 16 entries of 2-bit saturating counters; update index pc_plus4E[5:2], lookup index pc_plus4D[5:2].
REQ-017 On a resolve event, the indexed counter SHALL increment if taken (saturating at 3) and decrement if not taken (saturating at 0).
REQ-018 predict_takenD SHALL be combinational, counter[pc_plus4D[5:2]][1].
REQ-019 Same-index update and lookup in one cycle SHALL return the pre-update value; the new value is visible next cycle.
REQ-020 branch_cnt SHALL increment on every resolve event; mispredict_cnt on every mispredicting one; both SHALL saturate at 0xFFFFFFFF.
REQ-021 stallE=1 SHALL suppress resolve events; a stall in REDIRECT SHALL NOT extend REDIRECT.
REQ-022 Reserved cond encodings SHALL NOT occur on a branch; with branch_judge_controlE[4]=0 there SHALL be no resolve, no BHT or counter change.

Reset
REQ-023 With rst=0 at a clk edge: state=IDLE, redirect_valid=flushD_req=flushE_req=0, redirect_pc=0, branch_cnt=mispredict_cnt=0, all BHT counters=2'b01.
REQ-024 Reset while in REDIRECT SHALL abort the redirect: outputs are 0 on the cycle after the reset edge.

Verification
REQ-025 After reset, any pc_plus4D -> predict_takenD=0; counters 0.
REQ-026 BEQ, rs=rt=5, jump_conflictE=0, pcbranchE=0x100 -> next cycle redirect_valid=1, redirect_pc=0x100, flushD_req=flushE_req=1; the cycle after, all 0; mispredict_cnt=1.
REQ-027 BNE, rs=rt, jump_conflictE=0, pc_plus4E=0x40 -> no redirect, branch_cnt=1, BHT[0] 01->00.
REQ-028 BLTZ rs=0x80000000, jump_conflictE=1, pc_plus4E=0x44 -> no redirect; BHT[1] 01->10; lookup pc_plus4D=0x44 -> predict_takenD=1 next cycle.
REQ-029 Mispredicting branch with stallE=1 held for 3 cycles -> no redirect until stallE=0, then one-cycle redirect; branch_cnt increments once.
REQ-030 BGTZ rs=0 predicted taken at pc_plus4E=0xFFFFFFFC -> redirect_pc=0x00000000; then rst=0 during REDIRECT -> all outputs 0 next cycle.
